// File: rtl/gbuf_stream_reader_pkg.sv
// Shared definitions for the feature-map global buffer read path.
package gbuf_stream_reader_pkg;

   localparam int unsigned K_CHANNELS = 6;
   localparam int unsigned INT_WIDTH  = 8;
   localparam int unsigned SRAM_DEPTH = 16;
   localparam int unsigned FIFO_DEPTH = 3;
   localparam int unsigned BEAT_W     = K_CHANNELS * INT_WIDTH;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_RUN,
      RD_DRAIN
   } rd_state_e;

   typedef logic [K_CHANNELS-1:0][INT_WIDTH-1:0] beat_t;

endpackage

// File: rtl/gbuf_stream_reader_skid_fifo.sv
// Three-entry FIFO with registered occupancy; callers must never push when full or pop when empty.
module stream_skid_fifo
   import gbuf_stream_reader_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_async_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [1:0]       count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [1:0]       wr_ptr_q, wr_ptr_d;
   logic [1:0]       rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop_i) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + 2'(push_i) - 2'(pop_i);
   end

   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/gbuf_stream_reader.sv
// Walks an address window across all banks in lockstep and streams each word out under credit control.
module gbuf_stream_reader
   import gbuf_stream_reader_pkg::*;
#(
   parameter int unsigned DEPTH  = SRAM_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_async_n_i,
   input  logic                                  start_i,
   input  logic [ADDR_W-1:0]                     base_addr_i,
   input  logic [ADDR_W:0]                       len_i,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic [K_CHANNELS-1:0]                 rd_en_o,
   output logic [K_CHANNELS-1:0][ADDR_W-1:0]     rd_addr_o,
   input  logic [K_CHANNELS-1:0][INT_WIDTH-1:0]  rd_data_i,
   output logic                                  m_valid_o,
   input  logic                                  m_ready_i,
   output logic [K_CHANNELS-1:0][INT_WIDTH-1:0]  m_data_o,
   output logic                                  m_last_o
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   rd_state_e         state_q, state_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  issued_q, issued_d;
   logic [CNT_W-1:0]  popped_q, popped_d;
   logic [1:0]        reserved_q, reserved_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_en_q, rd_en_d;
   logic              cap_q;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              issue;
   logic              pop;
   logic              credit_ok;
   logic              fifo_valid;
   logic [1:0]        fifo_count;
   logic [BEAT_W-1:0] fifo_head;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

   assign fifo_valid = (fifo_count != 2'd0);
   assign pop        = fifo_valid && m_ready_i;
   // A same-cycle pop frees a slot, which keeps a steady-ready sink at one beat per cycle.
   assign credit_ok  = (reserved_q != 2'(FIFO_DEPTH)) || pop;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      issued_d  = issued_q;
      popped_d  = popped_q + CNT_W'(pop);
      addr_d    = addr_q;
      rd_addr_d = '0;
      done_d    = 1'b0;
      issue     = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  len_d     = len_i;
                  issued_d  = CNT_W'(1);
                  popped_d  = '0;
                  issue     = 1'b1;
                  rd_addr_d = base_addr_i;
                  addr_d    = next_addr(base_addr_i);
                  state_d   = RD_RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RD_RUN: begin
            if ((issued_q != len_q) && credit_ok) begin
               issue     = 1'b1;
               rd_addr_d = addr_q;
               addr_d    = next_addr(addr_q);
               issued_d  = issued_q + CNT_W'(1);
            end
            if (issued_d == len_q) state_d = RD_DRAIN;
         end
         RD_DRAIN: begin
            if (popped_d == len_q) begin
               state_d = RD_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = RD_IDLE;
      endcase
      reserved_d = reserved_q + 2'(issue) - 2'(pop);
      rd_en_d    = issue;
      busy_d     = (state_d != RD_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) begin
         state_q    <= RD_IDLE;
         len_q      <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         reserved_q <= '0;
         addr_q     <= '0;
         rd_addr_q  <= '0;
         rd_en_q    <= 1'b0;
         cap_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         popped_q   <= popped_d;
         reserved_q <= reserved_d;
         addr_q     <= addr_d;
         rd_addr_q  <= rd_addr_d;
         rd_en_q    <= rd_en_d;
         cap_q      <= rd_en_q;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   stream_skid_fifo #(
      .WIDTH (BEAT_W)
   ) u_fifo (
      .clk_i         (clk_i),
      .rst_async_n_i (rst_async_n_i),
      .push_i        (cap_q),
      .data_i        (rd_data_i),
      .pop_i         (pop),
      .count_o       (fifo_count),
      .head_o        (fifo_head)
   );

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign rd_en_o   = {K_CHANNELS{rd_en_q}};
   assign rd_addr_o = {K_CHANNELS{rd_addr_q}};
   assign m_valid_o = fifo_valid;
   assign m_data_o  = fifo_valid ? fifo_head : '0;
   assign m_last_o  = fifo_valid && (popped_q == (len_q - CNT_W'(1)));

endmodule

// File: tb/tb_gbuf_stream_reader.sv
// Directed bench for gbuf_stream_reader with a registered bank model and an expected-beat scoreboard.
module tb_gbuf_stream_reader;
   import gbuf_stream_reader_pkg::*;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   typedef struct {
      beat_t data;
      logic  last;
   } exp_t;

   logic                              clk_i = 1'b0;
   logic                              rst_async_n_i;
   logic                              start_i;
   logic [ADDR_W-1:0]                 base_addr_i;
   logic [ADDR_W:0]                   len_i;
   logic                              busy_o;
   logic                              done_o;
   logic [K_CHANNELS-1:0]             rd_en_o;
   logic [K_CHANNELS-1:0][ADDR_W-1:0] rd_addr_o;
   beat_t                             rd_data_i;
   logic                              m_valid_o;
   logic                              m_ready_i;
   beat_t                             m_data_o;
   logic                              m_last_o;

   int total = 0;
   int bad   = 0;
   int rd_en_cnt = 0;
   int pop_cnt   = 0;
   exp_t       exp_q[$];
   logic [3:0] addr_log[$];
   logic       prev_stall = 1'b0;
   beat_t      prev_data;

   always #5 clk_i = ~clk_i;

   gbuf_stream_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk_i         (clk_i),
      .rst_async_n_i (rst_async_n_i),
      .start_i       (start_i),
      .base_addr_i   (base_addr_i),
      .len_i         (len_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .rd_en_o       (rd_en_o),
      .rd_addr_o     (rd_addr_o),
      .rd_data_i     (rd_data_i),
      .m_valid_o     (m_valid_o),
      .m_ready_i     (m_ready_i),
      .m_data_o      (m_data_o),
      .m_last_o      (m_last_o)
   );

   // Bank k holds 16k+a at address a, one-cycle registered read.
   always @(posedge clk_i) begin
      for (int k = 0; k < K_CHANNELS; k++)
         if (rd_en_o[k]) rd_data_i[k] <= 8'(16 * k + int'(rd_addr_o[k]));
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t exp_beat(input int a);
      beat_t b;
      for (int k = 0; k < K_CHANNELS; k++) b[k] = 8'(16 * k + (a % DEPTH));
      return b;
   endfunction

   task automatic push_cmd(input int base, input int len);
      exp_t e;
      for (int i = 0; i < len; i++) begin
         e.data = exp_beat(base + i);
         e.last = (i == len - 1);
         exp_q.push_back(e);
      end
   endtask

   // Scoreboard: compare every handshake and check hold-under-stall.
   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_async_n_i) begin
         prev_stall = 1'b0;
      end else begin
         if (rd_en_o[0]) begin
            rd_en_cnt++;
            addr_log.push_back(rd_addr_o[0]);
         end
         if (prev_stall) chk("stall_hold_data", 64'(m_data_o), 64'(prev_data));
         if (!m_valid_o) chk("idle_data_zero", 64'(m_data_o), 64'd0);
         if (m_valid_o && m_ready_i) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", 64'(m_data_o), 64'(e.data));
               chk("beat_last", 64'(m_last_o), 64'(e.last));
            end
         end
         prev_stall = m_valid_o && !m_ready_i;
         prev_data  = m_data_o;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_cmd(input int base, input int len);
      start_i     = 1'b1;
      base_addr_i = 4'(base);
      len_i       = 5'(len);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int got;
      got = 0;
      for (int i = 0; i < budget && got == 0; i++) begin
         step();
         if (done_o) got = 1;
      end
      chk(tag, 64'(got), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy_o), 64'd0);
      chk({tag, "_done"}, 64'(done_o), 64'd0);
      chk({tag, "_rd_en"}, 64'(rd_en_o), 64'd0);
      chk({tag, "_rd_addr"}, 64'(rd_addr_o), 64'd0);
      chk({tag, "_valid"}, 64'(m_valid_o), 64'd0);
      chk({tag, "_data"}, 64'(m_data_o), 64'd0);
      chk({tag, "_last"}, 64'(m_last_o), 64'd0);
   endtask

   initial begin
      logic [3:0] wrap_exp [4];
      rst_async_n_i = 1'b0;
      start_i = 1'b0;
      base_addr_i = '0;
      len_i = '0;
      m_ready_i = 1'b1;
      repeat (3) step();
      check_all_zero("reset");
      rst_async_n_i = 1'b1;
      step();

      // Basic read: base 10, len 4, steady ready.
      start_cmd(10, 4);
      push_cmd(10, 4);
      step();
      start_i = 1'b0;
      chk("basic_busy_c1", 64'(busy_o), 64'd1);
      chk("basic_rd_en_c1", 64'(rd_en_o), 64'h3f);
      chk("basic_rd_addr_c1", 64'(rd_addr_o), 64'haaaaaa);
      step();
      chk("basic_valid_c2", 64'(m_valid_o), 64'd0);
      for (int c = 3; c <= 6; c++) begin
         step();
         chk("basic_valid", 64'(m_valid_o), 64'd1);
         chk("basic_last", 64'(m_last_o), 64'(c == 6));
         chk("basic_done_early", 64'(done_o), 64'd0);
      end
      step();
      chk("basic_done_c7", 64'(done_o), 64'd1);
      chk("basic_busy_c7", 64'(busy_o), 64'd0);
      chk("basic_drained", 64'(exp_q.size()), 64'd0);
      step();

      // Backpressure: ready low for cycles 0..12.
      m_ready_i = 1'b0;
      rd_en_cnt = 0;
      start_cmd(0, 8);
      push_cmd(0, 8);
      step();
      start_i = 1'b0;
      repeat (12) step();
      chk("bp_rd_en_before_pop", 64'(rd_en_cnt), 64'd3);
      chk("bp_valid_stalled", 64'(m_valid_o), 64'd1);
      m_ready_i = 1'b1;
      wait_done("bp_done_timeout", 60);
      chk("bp_all_beats", 64'(exp_q.size()), 64'd0);
      chk("bp_rd_en_total", 64'(rd_en_cnt), 64'd8);
      step();

      // Wrap: base 14, len 4.
      addr_log.delete();
      wrap_exp[0] = 4'd14; wrap_exp[1] = 4'd15; wrap_exp[2] = 4'd0; wrap_exp[3] = 4'd1;
      start_cmd(14, 4);
      push_cmd(14, 4);
      step();
      start_i = 1'b0;
      wait_done("wrap_done_timeout", 30);
      chk("wrap_addr_count", 64'(addr_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         chk("wrap_addr", 64'(addr_log[i]), 64'(wrap_exp[i]));
      chk("wrap_drained", 64'(exp_q.size()), 64'd0);
      step();

      // Zero length.
      pop_cnt = 0;
      rd_en_cnt = 0;
      start_cmd(5, 0);
      for (int c = 1; c <= 4; c++) begin
         step();
         start_i = 1'b0;
         chk("zero_done", 64'(done_o), 64'(c == 1));
         chk("zero_busy", 64'(busy_o), 64'd0);
         chk("zero_rd_en", 64'(rd_en_o), 64'd0);
         chk("zero_valid", 64'(m_valid_o), 64'd0);
      end

      // Start while busy is ignored.
      pop_cnt = 0;
      start_cmd(10, 4);
      push_cmd(10, 4);
      step();
      start_i = 1'b0;
      step();
      start_cmd(5, 7);
      for (int c = 3; c <= 10; c++) begin
         step();
         start_i = 1'b0;
         chk("sb_done", 64'(done_o), 64'(c == 7));
         if (c >= 8) chk("sb_no_second_read", 64'(rd_en_o), 64'd0);
      end
      chk("sb_beat_count", 64'(pop_cnt), 64'd4);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      // Mid-command reset at cycle 4, then restart base 3, len 2.
      start_cmd(0, 8);
      push_cmd(0, 8);
      step();
      start_i = 1'b0;
      repeat (3) step();
      rst_async_n_i = 1'b0;
      #1;
      check_all_zero("midrst");
      exp_q.delete();
      step();
      check_all_zero("midrst_hold");
      rst_async_n_i = 1'b1;
      step();
      chk("midrst_idle_valid", 64'(m_valid_o), 64'd0);
      pop_cnt = 0;
      start_cmd(3, 2);
      push_cmd(3, 2);
      step();
      start_i = 1'b0;
      wait_done("midrst_done_timeout", 30);
      chk("midrst_beat_count", 64'(pop_cnt), 64'd2);
      chk("midrst_drained", 64'(exp_q.size()), 64'd0);
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
